// File: rtl/llki_key_slot_if.sv
// Discrete LLKI key-slot bus between the upstream protocol processor and the
// core-side key slot; KEY_WORDS sizes the assembled key toward the core.
interface llki_key_slot_if #(
  parameter int unsigned KEY_WORDS = 2
);
  logic [63:0]             key_data;
  logic                    key_valid;
  logic                    clear_key;
  logic                    key_ready;
  logic                    key_complete;
  logic                    clear_key_ack;
  logic [64*KEY_WORDS-1:0] core_key;
  logic                    core_key_valid;
  logic [1:0]              slot_err;

  modport master (
    output key_data,
    output key_valid,
    output clear_key,
    input  key_ready,
    input  key_complete,
    input  clear_key_ack,
    input  core_key,
    input  core_key_valid,
    input  slot_err
  );

  modport slave (
    input  key_data,
    input  key_valid,
    input  clear_key,
    output key_ready,
    output key_complete,
    output clear_key_ack,
    output core_key,
    output core_key_valid,
    output slot_err
  );
endinterface

// File: rtl/llki_key_slot.sv
// Core-side LLKI key slot: stores key words with a per-word load latency,
// zeroises on request, and presents the assembled key to the locked core.
module llki_key_slot #(
  parameter int unsigned KEY_WORDS    = 2,
  parameter int unsigned LOAD_LATENCY = 3
) (
  input logic           clk,
  input logic           rst,
  llki_key_slot_if.slave slot_if
);

  generate
    if (KEY_WORDS < 1 || KEY_WORDS > 8) begin : g_bad_words
      $error("llki_key_slot: KEY_WORDS must be within 1..8");
    end
    if (LOAD_LATENCY < 1 || LOAD_LATENCY > 15) begin : g_bad_latency
      $error("llki_key_slot: LOAD_LATENCY must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_ACK
  } state_e;

  localparam logic [3:0] CNT_INIT   = 4'(LOAD_LATENCY - 1);
  localparam logic [3:0] WORDS_LAST = 4'(KEY_WORDS);

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [3:0]                  wr_idx_q, wr_idx_d;
  logic [3:0]                  clr_idx_q, clr_idx_d;
  logic                        complete_q, complete_d;
  logic [1:0]                  err_q, err_d;
  logic [KEY_WORDS-1:0][63:0]  words_q, words_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_idx_q   <= '0;
      clr_idx_q  <= '0;
      complete_q <= 1'b0;
      err_q      <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_idx_q   <= wr_idx_d;
      clr_idx_q  <= clr_idx_d;
      complete_q <= complete_d;
      err_q      <= err_d;
      words_q    <= words_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_idx_d   = wr_idx_q;
    clr_idx_d  = clr_idx_q;
    complete_d = complete_q;
    err_d      = err_q;
    words_d    = words_q;

    unique case (state_q)
      ST_IDLE: begin
        // A clear outranks a simultaneous word strobe: no store, no error.
        if (slot_if.clear_key) begin
          complete_d = 1'b0;
          clr_idx_d  = '0;
          state_d    = ST_CLEAR;
        end else if (slot_if.key_valid) begin
          if (complete_q) begin
            err_d[1] = 1'b1;
          end else begin
            for (int unsigned i = 0; i < KEY_WORDS; i++) begin
              if (wr_idx_q == 4'(i)) begin
                words_d[i] = slot_if.key_data;
              end
            end
            wr_idx_d = wr_idx_q + 4'd1;
            cnt_d    = CNT_INIT;
            state_d  = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (slot_if.clear_key) begin
          complete_d = 1'b0;
          clr_idx_d  = '0;
          state_d    = ST_CLEAR;
        end else begin
          if (slot_if.key_valid) begin
            err_d[0] = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            if (wr_idx_q == WORDS_LAST) begin
              complete_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end

      ST_CLEAR: begin
        if (slot_if.key_valid) begin
          err_d[0] = 1'b1;
        end
        // clr_idx runs one past the last word so the ack lands a cycle later.
        if (clr_idx_q == WORDS_LAST) begin
          state_d = ST_ACK;
        end else begin
          for (int unsigned i = 0; i < KEY_WORDS; i++) begin
            if (clr_idx_q == 4'(i)) begin
              words_d[i] = '0;
            end
          end
          clr_idx_d = clr_idx_q + 4'd1;
        end
      end

      ST_ACK: begin
        err_d    = '0;
        wr_idx_d = '0;
        state_d  = ST_IDLE;
        if (slot_if.key_valid) begin
          err_d[0] = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign slot_if.key_ready      = (state_q == ST_IDLE);
  assign slot_if.clear_key_ack  = (state_q == ST_ACK);
  assign slot_if.key_complete   = complete_q;
  assign slot_if.core_key_valid = complete_q;
  assign slot_if.core_key       = words_q;
  assign slot_if.slot_err       = err_q;

endmodule

// File: tb/tb_llki_key_slot.sv
// Directed plus randomized bench for llki_key_slot against a cycle-count
// reference model of the slot's load/clear timing rules.
module tb_llki_key_slot;

  localparam int unsigned KW = 2;
  localparam int unsigned LL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  llki_key_slot_if #(.KEY_WORDS(KW)) bus ();

  llki_key_slot #(
    .KEY_WORDS   (KW),
    .LOAD_LATENCY(LL)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .slot_if(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycles remaining until ready for load and clear.
  logic [63:0] m_words [KW];
  int          m_n;
  bit          m_complete;
  logic [1:0]  m_err;
  int          m_load;
  int          m_clr;

  task automatic model_reset();
    for (int i = 0; i < KW; i++) m_words[i] = '0;
    m_n        = 0;
    m_complete = 1'b0;
    m_err      = '0;
    m_load     = 0;
    m_clr      = 0;
  endtask

  task automatic model_edge(input bit v, input bit c, input logic [63:0] d);
    int k;
    if (m_clr > 0) begin
      k = KW + 3 - m_clr;
      if (k - 1 < KW) m_words[k-1] = '0;
      if (m_clr == 1) begin
        m_n   = 0;
        m_err = '0;
      end
      if (v) m_err[0] = 1'b1;
      m_clr--;
    end else if (c) begin
      m_complete = 1'b0;
      m_load     = 0;
      m_clr      = KW + 2;
    end else if (m_load > 0) begin
      if (v) m_err[0] = 1'b1;
      m_load--;
      if (m_load == 0 && m_n == KW) m_complete = 1'b1;
    end else if (v) begin
      if (m_complete) begin
        m_err[1] = 1'b1;
      end else begin
        m_words[m_n] = d;
        m_n++;
        m_load = LL;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [64*KW-1:0] ek;
    for (int i = 0; i < KW; i++) ek[64*i +: 64] = m_words[i];
    chk({tag, ".key_ready"},      128'(bus.key_ready),      128'(m_load == 0 && m_clr == 0));
    chk({tag, ".key_complete"},   128'(bus.key_complete),   128'(m_complete));
    chk({tag, ".clear_key_ack"},  128'(bus.clear_key_ack),  128'(m_clr == 1));
    chk({tag, ".core_key"},       128'(bus.core_key),       128'(ek));
    chk({tag, ".core_key_valid"}, 128'(bus.core_key_valid), 128'(m_complete));
    chk({tag, ".slot_err"},       128'(bus.slot_err),       128'(m_err));
  endtask

  task automatic step(input string tag, input bit v, input bit c, input logic [63:0] d);
    @(negedge clk);
    bus.key_valid = v;
    bus.clear_key = c;
    bus.key_data  = d;
    @(posedge clk);
    model_edge(v, c, d);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    logic [63:0] w0;
    logic [63:0] w1;
    logic [63:0] rd;
    bit          rv;
    bit          rc;

    w0 = 64'h0123456789ABCDEF;
    w1 = 64'hFEDCBA9876543210;
    bus.key_valid = 1'b0;
    bus.clear_key = 1'b0;
    bus.key_data  = '0;
    model_reset();

    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step("load_w0", 1'b1, 1'b0, w0);
    idle("lat_w0", LL);
    step("load_w1", 1'b1, 1'b0, w1);
    idle("lat_w1", LL);
    chk("loaded_key", 128'(bus.core_key), {w1, w0});
    chk("loaded_complete", 128'(bus.key_complete), 128'(1));

    step("overflow", 1'b1, 1'b0, 64'hDEADBEEF);
    chk("overflow_key", 128'(bus.core_key), {w1, w0});
    chk("overflow_err", 128'(bus.slot_err), 128'(2'b10));

    step("clear", 1'b0, 1'b1, 64'h0);
    idle("clear_seq", KW + 2);
    chk("cleared_key", 128'(bus.core_key), 128'(0));
    chk("cleared_err", 128'(bus.slot_err), 128'(0));

    step("load_a", 1'b1, 1'b0, w1);
    step("valid_in_load", 1'b1, 1'b0, 64'h5555);
    chk("load_err0", 128'(bus.slot_err), 128'(2'b01));
    step("abort_clear", 1'b0, 1'b1, 64'h0);
    idle("abort_seq", KW + 3);

    step("load_b", 1'b1, 1'b0, w0);
    idle("lat_b", LL);
    step("clr_and_valid", 1'b1, 1'b1, 64'h1111);
    chk("clr_and_valid_err", 128'(bus.slot_err), 128'(0));
    idle("cv_seq", 2);

    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid_clear");
    @(negedge clk);
    rst = 1'b0;
    idle("post_rst", 2);

    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(3, 0) == 0);
      rc = ($urandom_range(15, 0) == 0);
      rd = {$urandom, $urandom};
      step("rand", rv, rc, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
